// File: rtl/rom_stream_reader.sv
// rom_stream_reader
//
// Read-side master for a synchronous lookup ROM with a registered output.
// It fetches a programmed run of consecutive words, starting at START_ADDR
// and wrapping modulo the ROM depth. Each word is streamed out on a
// valid/ready interface, and a running XOR checksum of the accepted words
// is kept.
//
// Ports
//   CLK         system clock, rising edge
//   RST         asynchronous, active-high reset
//   START       begin a run (sampled only in IDLE)
//   START_ADDR  first ROM address of the run
//   LEN         number of words, 0 .. 2^ADDR_W
//   ROM_ADDR    registered address to the ROM
//   ROM_DATA    ROM output, valid one cycle after the ROM samples ROM_ADDR
//   OUT_DATA    streamed word
//   OUT_VALID   OUT_DATA valid
//   OUT_READY   consumer accepts word
//   BUSY        run in progress (FETCH, CAPTURE, PRESENT, FIN)
//   DONE        one-cycle pulse in FIN
//   CHECKSUM    XOR of the words accepted in the current or last run
//   DBG_STATE   current FSM state encoding (IDLE=0, FETCH=1, CAPTURE=2,
//               PRESENT=3, FIN=4)
//
// Handshake: a word transfers at a rising edge where OUT_VALID and OUT_READY
// are both 1. Once raised, OUT_VALID and OUT_DATA stay stable until that
// edge. OUT_READY has no effect while OUT_VALID is 0.

module rom_stream_reader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [ADDR_W:0]   LEN,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [DATA_W-1:0] ROM_DATA,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] CHECKSUM,
    output logic [2:0]        DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_PRESENT = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_rem;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_checksum;

    logic              w_handshake;
    logic              w_last;
    logic [ADDR_W-1:0] w_ptr_next;

    assign w_handshake = r_out_valid & OUT_READY;
    assign w_last      = (r_rem == {{ADDR_W{1'b0}}, 1'b1});
    // Natural width overflow gives the wrap from 2^ADDR_W-1 back to 0.
    assign w_ptr_next  = r_ptr + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_rem       <= '0;
            r_rom_addr  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_checksum  <= '0;
        end else begin
            // DONE is high only during the single FIN cycle.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_checksum <= '0;
                        r_busy     <= 1'b1;
                        if (LEN != '0) begin
                            r_ptr      <= START_ADDR;
                            r_rom_addr <= START_ADDR;
                            r_rem      <= LEN;
                            r_state    <= S_FETCH;
                        end else begin
                            // Empty run: go straight to the completion pulse.
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                end
                S_FETCH: begin
                    // ROM_ADDR is held; the ROM samples it at this edge.
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_out_data  <= ROM_DATA;
                    r_out_valid <= 1'b1;
                    r_state     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (w_handshake) begin
                        r_checksum  <= r_checksum ^ r_out_data;
                        r_out_valid <= 1'b0;
                        r_rem       <= r_rem - 1'b1;
                        r_ptr       <= w_ptr_next;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_rom_addr <= w_ptr_next;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ROM_ADDR  = r_rom_addr;
    assign OUT_DATA  = r_out_data;
    assign OUT_VALID = r_out_valid;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign CHECKSUM  = r_checksum;
    assign DBG_STATE = r_state;

endmodule
